// File: rtl/uart_loader.sv
// UART boot loader: receives a length-prefixed 8N1 image and writes it word by word to program memory.
// Optional trailing XOR checksum byte is enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_loader #(
  parameter int          CLK_FREQ  = 100000000,
  parameter int          BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int          HALF_BIT     = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam int          CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [31:0] MAX_WORDS_32 = 32'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    M_LEN,
    M_DATA,
`ifdef UART_LOADER_CHECKSUM_EN
    M_SUM,
`endif
    M_DONE,
    M_ERR
  } m_state_t;

  logic             rxd_meta_r, rxd_sync_r, rxd_prev_r;
  rx_state_t        rx_state_r, rx_state_s;
  logic [CNT_W-1:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]       rx_bit_r, rx_bit_s;
  logic [7:0]       rx_shift_r, rx_shift_s;
  logic             byte_valid_r, byte_valid_s;
  logic             frame_err_r, frame_err_s;

  m_state_t         m_state_r, m_state_s;
  logic [1:0]       byte_cnt_r, byte_cnt_s;
  logic [31:0]      len_r, len_s;
  logic [31:0]      word_r, word_s;
  logic [31:0]      index_r, index_s;
  logic [7:0]       csum_r, csum_s;
  logic             we_r, we_s;
  logic [31:0]      addr_r, addr_s;
  logic [31:0]      wd_r, wd_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             err_r, err_s;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // Receiver next-state: start bit checked at half a bit, then full-bit spaced samples.
  always_comb begin
    rx_state_s   = rx_state_r;
    rx_cnt_s     = rx_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    rx_bit_s     = rx_bit_r;
    rx_shift_s   = rx_shift_r;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = {CNT_W{1'b0}};
        if (rxd_prev_r && !rxd_sync_r) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_s = {CNT_W{1'b0}};
          rx_bit_s = 3'd0;
          if (rxd_sync_r) begin
            rx_state_s = RX_IDLE;
          end else begin
            rx_state_s = RX_DATA;
          end
        end else begin
          rx_state_s = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = {CNT_W{1'b0}};
          rx_shift_s = {rxd_sync_r, rx_shift_r[7:1]};
          rx_bit_s   = rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            rx_state_s = RX_DATA;
          end
        end else begin
          rx_state_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = {CNT_W{1'b0}};
          rx_state_s = RX_IDLE;
          if (rxd_sync_r) begin
            byte_valid_s = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else begin
          rx_state_s = RX_STOP;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r   <= RX_IDLE;
      rx_cnt_r     <= {CNT_W{1'b0}};
      rx_bit_r     <= 3'd0;
      rx_shift_r   <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      rx_state_r   <= rx_state_s;
      rx_cnt_r     <= rx_cnt_s;
      rx_bit_r     <= rx_bit_s;
      rx_shift_r   <= rx_shift_s;
      byte_valid_r <= byte_valid_s;
      frame_err_r  <= frame_err_s;
    end
  end

  // Loader next-state; busy is released one cycle after the final write so we never overlaps busy=0.
  always_comb begin
    m_state_s  = m_state_r;
    byte_cnt_s = byte_cnt_r;
    len_s      = len_r;
    word_s     = word_r;
    index_s    = index_r;
    csum_s     = csum_r;
    we_s       = 1'b0;
    addr_s     = addr_r;
    wd_s       = wd_r;
    busy_s     = busy_r;
    done_s     = done_r;
    err_s      = err_r;
    case (m_state_r)
      M_LEN: begin
        if (frame_err_r) begin
          m_state_s = M_ERR;
          err_s     = 1'b1;
        end else if (byte_valid_r) begin
          len_s      = {rx_shift_r, len_r[31:8]};
          byte_cnt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            index_s = 32'd0;
            csum_s  = 8'h00;
            if (len_s == 32'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
              m_state_s = M_SUM;
`else
              m_state_s = M_DONE;
              busy_s    = 1'b0;
              done_s    = 1'b1;
`endif
            end else if (len_s > MAX_WORDS_32) begin
              m_state_s = M_ERR;
              err_s     = 1'b1;
            end else begin
              m_state_s = M_DATA;
            end
          end else begin
            m_state_s = M_LEN;
          end
        end else begin
          m_state_s = M_LEN;
        end
      end
      M_DATA: begin
        if (frame_err_r) begin
          m_state_s = M_ERR;
          err_s     = 1'b1;
        end else if (byte_valid_r) begin
          word_s     = {rx_shift_r, word_r[31:8]};
          csum_s     = csum_r ^ rx_shift_r;
          byte_cnt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            we_s    = 1'b1;
            addr_s  = BASE_ADDR + (index_r << 2);
            wd_s    = word_s;
            index_s = index_r + 32'd1;
            if (index_r == len_r - 32'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
              m_state_s = M_SUM;
`else
              m_state_s = M_DONE;
`endif
            end else begin
              m_state_s = M_DATA;
            end
          end else begin
            m_state_s = M_DATA;
          end
        end else begin
          m_state_s = M_DATA;
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      M_SUM: begin
        if (frame_err_r) begin
          m_state_s = M_ERR;
          err_s     = 1'b1;
        end else if (byte_valid_r) begin
          if (rx_shift_r == csum_r) begin
            m_state_s = M_DONE;
            busy_s    = 1'b0;
            done_s    = 1'b1;
          end else begin
            m_state_s = M_ERR;
            err_s     = 1'b1;
          end
        end else begin
          m_state_s = M_SUM;
        end
      end
`endif
      M_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      M_ERR: begin
        busy_s = 1'b1;
        done_s = 1'b0;
        err_s  = 1'b1;
      end
      default: begin
        m_state_s = M_ERR;
        busy_s    = 1'b1;
        err_s     = 1'b1;
      end
    endcase
  end

  // Loader state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_state_r  <= M_LEN;
      byte_cnt_r <= 2'd0;
      len_r      <= 32'd0;
      word_r     <= 32'd0;
      index_r    <= 32'd0;
      csum_r     <= 8'h00;
      we_r       <= 1'b0;
      addr_r     <= BASE_ADDR;
      wd_r       <= 32'd0;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      m_state_r  <= m_state_s;
      byte_cnt_r <= byte_cnt_s;
      len_r      <= len_s;
      word_r     <= word_s;
      index_r    <= index_s;
      csum_r     <= csum_s;
      we_r       <= we_s;
      addr_r     <= addr_s;
      wd_r       <= wd_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  assign we   = we_r;
  assign addr = addr_r;
  assign wd   = wd_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed and random images checked against a byte-level model of the loader protocol.
module tb_uart_loader;

  localparam int CPB       = 10;
  localparam int MAX_WORDS = 256;

  typedef logic [7:0] bytes_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mon_addr_q[$];
  logic [31:0] mon_data_q[$];
  int          mon_cyc_q[$];
  int          idle_we;
  logic        done_seen;
  int          done_cyc;
  int          stop_cyc_q[$];

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_last_q[$];
  int          exp_state;

  uart_loader #(
    .CLK_FREQ (1000000),
    .BAUD     (100000),
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .we  (we),
    .addr(addr),
    .wd  (wd),
    .busy(busy),
    .done(done),
    .err (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: logs every write and the first cycle done is seen.
  always @(negedge clk) begin
    if (rst) begin
      mon_addr_q.delete();
      mon_data_q.delete();
      mon_cyc_q.delete();
      idle_we   <= 0;
      done_seen <= 1'b0;
      done_cyc  <= 0;
    end else begin
      if (we === 1'b1) begin
        mon_addr_q.push_back(addr);
        mon_data_q.push_back(wd);
        mon_cyc_q.push_back(cyc);
        if (busy !== 1'b1) idle_we <= idle_we + 1;
      end
      if (done === 1'b1 && !done_seen) begin
        done_seen <= 1'b1;
        done_cyc  <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      bit_time();
    end
    rxd = stop_bit;
    stop_cyc_q.push_back(cyc);
    bit_time();
    rxd = 1'b1;
    bit_time();
    bit_time();
  endtask

  task automatic send_all(input bytes_t b, input int bad);
    stop_cyc_q.delete();
    foreach (b[i]) send_byte(b[i], (i == bad) ? 1'b0 : 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Appends the checksum byte (XOR of the data bytes) when the design expects one.
  function automatic bytes_t with_sum(input bytes_t b);
    bytes_t r;
    logic [7:0] x;
    r = b;
    x = 8'h00;
    for (int i = 4; i < b.size(); i++) x ^= b[i];
`ifdef UART_LOADER_CHECKSUM_EN
    r.push_back(x);
`endif
    return r;
  endfunction

  // Protocol model: state 0 = still loading, 1 = done, 2 = error.
  function automatic void model(input bytes_t b, input int bad);
    logic [31:0] len;
    logic [7:0]  x;
    int          n;
    int          p;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_last_q.delete();
    exp_state = 0;
    n = b.size();
    for (int i = 0; i < 4; i++) begin
      if (i >= n) return;
      if (i == bad) begin
        exp_state = 2;
        return;
      end
    end
    len = {b[3], b[2], b[1], b[0]};
    if (len > MAX_WORDS) begin
      exp_state = 2;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < int'(len); k++) begin
      for (int j = 0; j < 4; j++) begin
        p = 4 + 4 * k + j;
        if (p >= n) return;
        if (p == bad) begin
          exp_state = 2;
          return;
        end
        x ^= b[p];
      end
      p = 4 + 4 * k;
      exp_addr_q.push_back(32'(4 * k));
      exp_data_q.push_back({b[p+3], b[p+2], b[p+1], b[p]});
      exp_last_q.push_back(p + 3);
    end
`ifdef UART_LOADER_CHECKSUM_EN
    p = 4 + 4 * int'(len);
    if (p >= n) return;
    if (p == bad) begin
      exp_state = 2;
      return;
    end
    exp_state = (b[p] == x) ? 1 : 2;
`else
    exp_state = 1;
`endif
  endfunction

  task automatic check_result(input string tag, input bytes_t b, input int bad);
    int lat;
    model(b, bad);
    chk({tag, "_nwr"}, 32'(mon_addr_q.size()), 32'(exp_addr_q.size()));
    for (int k = 0; k < exp_addr_q.size() && k < mon_addr_q.size(); k++) begin
      chk({tag, "_addr"}, mon_addr_q[k], exp_addr_q[k]);
      chk({tag, "_wd"}, mon_data_q[k], exp_data_q[k]);
      lat = mon_cyc_q[k] - stop_cyc_q[exp_last_q[k]];
      chk({tag, "_we_lat"}, 32'(lat >= 7 && lat <= 9), 32'd1);
    end
    chk({tag, "_done"}, 32'(done), 32'(exp_state == 1));
    chk({tag, "_err"}, 32'(err), 32'(exp_state == 2));
    chk({tag, "_busy"}, 32'(busy), 32'(exp_state != 1));
    chk({tag, "_we_idle"}, 32'(idle_we), 32'd0);
  endtask

  task automatic load(input string tag, input bytes_t b, input int bad);
    send_all(b, bad);
    repeat (40) @(posedge clk);
    #2;
    check_result(tag, b, bad);
  endtask

  task automatic run_image(input string tag, input bytes_t b, input int bad);
    do_reset();
    load(tag, b, bad);
  endtask

  initial begin
    bytes_t img;
    bytes_t extra;
    int     d;
    int     len;
    int     bad;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_wd", wd, 32'h0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    img = with_sum('{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                     8'hDD, 8'hCC, 8'hBB, 8'hAA});
    run_image("normal", img, -1);
    extra = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h55};
    send_all(extra, -1);
    repeat (20) @(posedge clk);
    #2;
    chk("normal_after_nwr", 32'(mon_addr_q.size()), 32'd2);
    chk("normal_after_done", 32'(done), 32'd1);
    do_reset();
    #1;
    chk("rerst_addr", addr, 32'h0);
    chk("rerst_wd", wd, 32'h0);
    chk("rerst_busy", 32'(busy), 32'd1);
    chk("rerst_done", 32'(done), 32'd0);

    img = with_sum('{8'h00, 8'h00, 8'h00, 8'h00});
    run_image("empty", img, -1);
    d = done_cyc - stop_cyc_q[img.size() - 1];
    chk("empty_done_lat", 32'(d >= 6 && d <= 10), 32'd1);

    img = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88};
    run_image("oversize", img, -1);

    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33};
    run_image("frame", img, 5);

    do_reset();
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33};
    send_all(img, -1);
    repeat (5) @(posedge clk);
    #2;
    chk("midword_nwr", 32'(mon_addr_q.size()), 32'd0);
    do_reset();
    img = with_sum('{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
    load("midword", img, -1);

`ifdef UART_LOADER_CHECKSUM_EN
    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    run_image("sum_ok", img, -1);
    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45};
    run_image("sum_bad", img, -1);
`endif

    for (int t = 0; t < 6; t++) begin
      img.delete();
      len = $urandom_range(0, 4);
      img.push_back(8'(len));
      img.push_back(8'h00);
      img.push_back(($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00);
      img.push_back(8'h00);
      for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom));
      img = with_sum(img);
`ifdef UART_LOADER_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) img[img.size() - 1] ^= 8'($urandom_range(1, 255));
`endif
      for (int i = $urandom_range(0, 2); i > 0; i--) img.push_back(8'($urandom));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, img.size() - 1)) : -1;
      run_image($sformatf("rand%0d", t), img, bad);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
